seq_array_multiplier: RTL and testbench

//  Parametrised WIDTH x WIDTH iterative shift-add multiplier; successor to the 4x4 combinational array multiplier.

---
 rtl/seq_array_multiplier_pkg.sv | 10 +
 rtl/seq_array_multiplier_if.sv | 21 ++
 rtl/seq_array_multiplier_add_row.sv | 11 +
 rtl/seq_array_multiplier.sv | 112 +++++++++++
 tb/tb_seq_array_multiplier.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_array_multiplier_pkg.sv
// Shared state encoding and limits for the iterative shift-add multiplier.
package mult_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_MAX_WIDTH = 32;
endpackage

// File: rtl/seq_array_multiplier_if.sv
// Operand/result handshake bundle; master is the operand source plus result sink.
interface seq_array_multiplier_if #(parameter int WIDTH = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_array_multiplier_add_row.sv
// Single WIDTH-bit adder row with carry out, reused every iteration of the multiplier.
module mult_add_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

// File: rtl/seq_array_multiplier.sv
// WIDTH x WIDTH shift-add multiplier, one adder row per cycle, product after WIDTH cycles.
// Optional MULT_SIGNED_EN: two's complement operands/product via magnitude multiply and sign fix-up.
module seq_array_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_array_multiplier_if.slave bus
);
  localparam int              CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > MULT_MAX_WIDTH) begin : g_bad_width
    $error("seq_array_multiplier: WIDTH out of range");
  end

  mult_state_t        r_state;
  mult_state_t        w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_result;
  logic               w_accept;
  logic               w_last;

`ifdef MULT_SIGNED_EN
  logic r_neg;

  // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
  assign w_a_mag  = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_b_mag  = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign w_result = r_neg ? -w_acc_step : w_acc_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end
`else
  assign w_a_mag  = bus.a;
  assign w_b_mag  = bus.b;
  assign w_result = w_acc_step;
`endif

  assign w_addend = r_acc[0] ? r_mcand : '0;

  mult_add_row #(.WIDTH(WIDTH)) u_add_row (
    .i_a    (r_acc[2*WIDTH-1:WIDTH]),
    .i_b    (w_addend),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Carry lands in the top bit as the partial product shifts right.
  assign w_acc_step = {w_cout, w_sum, r_acc[WIDTH-1:1]};
  assign w_accept   = (r_state == IDLE) && bus.in_valid;
  assign w_last     = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = CALC;
      CALC:    if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand <= w_a_mag;
      r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
      r_cnt   <= '0;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_product <= w_result;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.product   = r_product;
endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed + random scoreboard bench for seq_array_multiplier at WIDTH=8 and WIDTH=4.
module tb_seq_array_multiplier;
  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_in8 = 0, n_out8 = 0, n_disc8 = 0;
  int   n_in4 = 0, n_out4 = 0;
  logic [63:0] q8[$];
  logic [63:0] q4[$];

  seq_array_multiplier_if #(.WIDTH(8)) bus8 ();
  seq_array_multiplier_if #(.WIDTH(4)) bus4 ();

  seq_array_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  seq_array_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
`ifdef MULT_SIGNED_EN
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
`else
    sa = longint'(a);
    sb = longint'(b);
`endif
    p = sa * sb;
    return 64'(p) & mask;
  endfunction

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: records the handshakes the next rising edge will take.
  task automatic step();
    if (!rst) begin
      if (bus8.in_valid && bus8.in_ready) begin
        q8.push_back(model(8, 32'(bus8.a), 32'(bus8.b)));
        n_in8++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        n_out8++;
        check("sb8_pending", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) check("sb8_product", 64'(bus8.product), q8.pop_front());
      end
      if (bus4.in_valid && bus4.in_ready) begin
        q4.push_back(model(4, 32'(bus4.a), 32'(bus4.b)));
        n_in4++;
      end
      if (bus4.out_valid && bus4.out_ready) begin
        n_out4++;
        check("sb4_pending", 64'(q4.size() > 0), 64'd1);
        if (q4.size() > 0) check("sb4_product", 64'(bus4.product), q4.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_vld8(input string tag);
    int k = 0;
    while (!bus8.out_valid && k < 100) begin
      step();
      k++;
    end
    check(tag, 64'(bus8.out_valid), 64'd1);
  endtask

  task automatic wait_vld4(input string tag);
    int k = 0;
    while (!bus4.out_valid && k < 100) begin
      step();
      k++;
    end
    check(tag, 64'(bus4.out_valid), 64'd1);
  endtask

  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    bus4.a        = a;
    bus4.b        = b;
    bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    wait_vld4({tag, "_vld"});
    check({tag, "_lit"}, 64'(bus4.product), 64'(exp));
    step();
  endtask

  initial begin
    int lat, seen, sent, guard, k;
    logic hs;

    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst8_in_ready",  64'(bus8.in_ready),  64'd1);
    check("rst8_out_valid", 64'(bus8.out_valid), 64'd0);
    check("rst8_busy",      64'(bus8.busy),      64'd0);
    check("rst8_product",   64'(bus8.product),   64'd0);
    check("rst4_in_ready",  64'(bus4.in_ready),  64'd1);
    check("rst4_out_valid", 64'(bus4.out_valid), 64'd0);
    check("rst4_busy",      64'(bus4.busy),      64'd0);
    check("rst4_product",   64'(bus4.product),   64'd0);

    // 15 x 15 at WIDTH=4 with exact latency from the accept edge
    bus4.a = 4'hF; bus4.b = 4'hF; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin
      check("t1_busy", 64'(bus4.busy), 64'd1);
      step();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'd4);
`ifdef MULT_SIGNED_EN
    check("t1_product", 64'(bus4.product), 64'h01);
`else
    check("t1_product", 64'(bus4.product), 64'hE1);
`endif
    check("t1_in_ready_done", 64'(bus4.in_ready), 64'd0);
    step();
    check("t1_in_ready_after", 64'(bus4.in_ready), 64'd1);

    // Back-to-back at WIDTH=8: second pair presented while the first is in flight
    bus8.a = 8'h00; bus8.b = 8'hFF; bus8.in_valid = 1'b1;
    step();
    bus8.a = 8'hFF; bus8.b = 8'hFF;
    wait_vld8("t2a_vld");
    check("t2a_product", 64'(bus8.product), 64'h0000);
    check("t2a_in_ready", 64'(bus8.in_ready), 64'd0);
    step();
    check("t2_in_ready_rise", 64'(bus8.in_ready), 64'd1);
    step();
    bus8.in_valid = 1'b0;
    wait_vld8("t2b_vld");
`ifdef MULT_SIGNED_EN
    check("t2b_product", 64'(bus8.product), 64'h0001);
`else
    check("t2b_product", 64'(bus8.product), 64'hFE01);
`endif
    step();

    // Backpressure: result held for 10 cycles while new operands are offered
    bus8.out_ready = 1'b0;
    bus8.a = 8'd12; bus8.b = 8'd11; bus8.in_valid = 1'b1;
    step();
    bus8.a = 8'd3; bus8.b = 8'd5;
    wait_vld8("t3_vld");
    k = n_out8;
    for (int i = 0; i < 10; i++) begin
      check("t3_product", 64'(bus8.product), 64'd132);
      check("t3_out_valid", 64'(bus8.out_valid), 64'd1);
      check("t3_in_ready", 64'(bus8.in_ready), 64'd0);
      step();
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    step();
    check("t3_handshakes", 64'(n_out8 - k), 64'd1);
    check("t3_out_valid_clr", 64'(bus8.out_valid), 64'd0);
    check("t3_in_ready_back", 64'(bus8.in_ready), 64'd1);

    // Reset three cycles after accept discards the operation
    bus8.a = 8'd100; bus8.b = 8'd3; bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_disc8 += q8.size();
    q8.delete();
    check("t4_out_valid", 64'(bus8.out_valid), 64'd0);
    check("t4_in_ready",  64'(bus8.in_ready),  64'd1);
    check("t4_product",   64'(bus8.product),   64'd0);
    check("t4_busy",      64'(bus8.busy),      64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.out_valid) seen++;
      step();
    end
    check("t4_no_result", 64'(seen), 64'd0);
    check("t4_discarded", 64'(n_disc8), 64'd1);

    // Sign corner cases at WIDTH=4 (plain products when unsigned)
`ifdef MULT_SIGNED_EN
    op4("t5_m8x7",  4'h8, 4'h7, 8'hC8);
    op4("t5_m8xm8", 4'h8, 4'h8, 8'h40);
    op4("t5_m1x1",  4'hF, 4'h1, 8'hFF);
`else
    op4("t5_8x7",   4'h8, 4'h7, 8'h38);
    op4("t5_8x8",   4'h8, 4'h8, 8'h40);
    op4("t5_15x1",  4'hF, 4'h1, 8'h0F);
`endif

    // Random traffic with gaps on both sides
    sent  = 0;
    guard = 0;
    while (sent < 1000 && guard < 60000) begin
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus8.in_valid && $urandom_range(0, 1) == 1) begin
        bus8.a = rnd8();
        bus8.b = rnd8();
        bus8.in_valid = 1'b1;
      end
      hs = bus8.in_valid && bus8.in_ready;
      step();
      if (hs) begin
        sent++;
        bus8.in_valid = 1'b0;
      end
      guard++;
    end
    check("t6_sent", 64'(sent), 64'd1000);
    bus8.out_ready = 1'b1;
    k = 0;
    while (q8.size() > 0 && k < 100) begin
      step();
      k++;
    end
    repeat (3) step();
    check("t6_drained", 64'(q8.size()), 64'd0);
    check("t6_count8", 64'(n_out8), 64'(n_in8 - n_disc8));
    check("t6_count4", 64'(n_out4), 64'(n_in4));
    check("t6_queue4", 64'(q4.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
